// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA animation sequencer.
package vga_pkg;

  localparam int unsigned CoordW = 10;

  typedef logic [CoordW-1:0] coord_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2
  } state_e;

  typedef enum logic {
    ModeWrap   = 1'b0,
    ModeBounce = 1'b1
  } mode_e;

endpackage

// File: rtl/vga_anim_sequencer_if.sv
// Config/status bundle between the timing generator side and the animation sequencer.
interface vga_anim_sequencer_if
  import vga_pkg::*;
();

  logic        vsync;
  logic        enable;
  logic        pause;
  logic        mode;
  logic [3:0]  speed;
  coord_t      scroll_x;
  logic [1:0]  palette_sel;
  logic [7:0]  frame_count;
  logic        frame_tick;
  logic [1:0]  state;
  logic        dir;

  modport master (
    output vsync, enable, pause, mode, speed,
    input  scroll_x, palette_sel, frame_count, frame_tick, state, dir
  );

  modport slave (
    input  vsync, enable, pause, mode, speed,
    output scroll_x, palette_sel, frame_count, frame_tick, state, dir
  );

endinterface

// File: rtl/vga_frame_edge.sv
// vsync rising-edge detector producing a registered one-cycle frame tick.
module vga_frame_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic frame_tick
);

  logic vsync_q;
  logic tick_q;

  // vsync_q resets high so a vsync already high at release is not seen as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      vsync_q <= vsync;
      tick_q  <= vsync & ~vsync_q;
    end
  end

  assign frame_tick = tick_q;

endmodule

// File: rtl/vga_anim_sequencer.sv
// Frame-rate animation FSM: scroll offset, palette cycling and frame counting per vsync.
module vga_anim_sequencer
  import vga_pkg::*;
#(
  parameter int unsigned X_MAX        = 511,
  parameter int unsigned PAL_DIV_LOG2 = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  vga_anim_sequencer_if.slave bus
);

  localparam coord_t            XMaxC   = coord_t'(X_MAX);
  localparam logic [CoordW:0]   XMaxW   = (CoordW + 1)'(X_MAX);
  localparam logic [7:0]        PalMask = 8'((1 << PAL_DIV_LOG2) - 1);

  logic frame_tick;

  vga_frame_edge u_frame_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .vsync      (bus.vsync),
    .frame_tick (frame_tick)
  );

  state_e     state_q, state_d;
  coord_t     scroll_q, scroll_d;
  logic       dir_q, dir_d;
  logic [7:0] fc_q, fc_d;
  logic [1:0] pal_q, pal_d;
  logic       mode_prev_q, mode_prev_d;

  // Motion datapath: sums are one bit wider than the coordinate so bounce compares never wrap.
  coord_t          speed_c;
  logic [CoordW:0] sum;
  logic            switch_clamp;
  coord_t          next_x;
  logic            next_dir;
  logic [7:0]      fc_inc;
  logic            pal_step;

  assign speed_c      = coord_t'(bus.speed);
  assign sum          = {1'b0, scroll_q} + (CoordW + 1)'(bus.speed);
  assign switch_clamp = (mode_e'(bus.mode) == ModeBounce) && !mode_prev_q &&
                        ({1'b0, scroll_q} > XMaxW);
  assign fc_inc       = fc_q + 8'd1;
  assign pal_step     = (fc_inc & PalMask) == 8'd0;

  always_comb begin
    next_x   = scroll_q;
    next_dir = dir_q;
    if (switch_clamp) begin
      // Entering bounce from an offset wrap mode left out of range.
      next_x   = XMaxC;
      next_dir = 1'b1;
    end else if (mode_e'(bus.mode) == ModeWrap) begin
      next_x = sum[CoordW-1:0];
    end else if (!dir_q) begin
      if (sum > XMaxW) begin
        next_x   = XMaxC;
        next_dir = 1'b1;
      end else begin
        next_x = sum[CoordW-1:0];
      end
    end else if (scroll_q < speed_c) begin
      next_x   = '0;
      next_dir = 1'b0;
    end else begin
      next_x = scroll_q - speed_c;
    end
  end

  always_comb begin
    logic clear;
    clear       = 1'b0;
    state_d     = state_q;
    scroll_d    = scroll_q;
    dir_d       = dir_q;
    fc_d        = fc_q;
    pal_d       = pal_q;
    mode_prev_d = mode_prev_q;
    if (frame_tick) begin
      unique case (state_q)
        StIdle: begin
          if (bus.enable) state_d = StRun;
        end
        StRun: begin
          if (!bus.enable) begin
            clear = 1'b1;
          end else if (bus.pause) begin
            state_d = StHold;
          end else begin
            scroll_d    = next_x;
            dir_d       = next_dir;
            fc_d        = fc_inc;
            mode_prev_d = bus.mode;
            if (pal_step) pal_d = pal_q + 2'd1;
          end
        end
        StHold: begin
          if (!bus.enable) begin
            clear = 1'b1;
          end else if (!bus.pause) begin
            state_d = StRun;
          end
        end
        default: clear = 1'b1;
      endcase
      if (clear) begin
        state_d     = StIdle;
        scroll_d    = '0;
        dir_d       = 1'b0;
        fc_d        = '0;
        pal_d       = '0;
        mode_prev_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      scroll_q    <= '0;
      dir_q       <= 1'b0;
      fc_q        <= '0;
      pal_q       <= '0;
      mode_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      scroll_q    <= scroll_d;
      dir_q       <= dir_d;
      fc_q        <= fc_d;
      pal_q       <= pal_d;
      mode_prev_q <= mode_prev_d;
    end
  end

  assign bus.scroll_x    = scroll_q;
  assign bus.palette_sel = pal_q;
  assign bus.frame_count = fc_q;
  assign bus.frame_tick  = frame_tick;
  assign bus.state       = state_q;
  assign bus.dir         = dir_q;

endmodule

// File: tb/tb_vga_anim_sequencer.sv
// Randomized self-checking bench for vga_anim_sequencer against a frame-level behavioural model.
module tb_vga_anim_sequencer;

  localparam int XMax = 511;
  localparam int PalLog2 = 4;

  logic clk;
  logic rst_n;

  vga_anim_sequencer_if bus ();

  vga_anim_sequencer #(
    .X_MAX        (XMax),
    .PAL_DIV_LOG2 (PalLog2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int tick_cnt = 0;

  always @(posedge clk) if (bus.frame_tick === 1'b1) tick_cnt <= tick_cnt + 1;

  // Behavioural model state, one update per frame boundary.
  int m_state, m_x, m_dir, m_fc, m_pal, m_prev_mode;
  logic tick_hi, tick_lo;

  function automatic logic [22:0] exp_vec();
    return {2'(m_state), 10'(m_x), 1'(m_dir), 8'(m_fc), 2'(m_pal)};
  endfunction

  function automatic logic [22:0] dut_vec();
    return {bus.state, bus.scroll_x, bus.dir, bus.frame_count, bus.palette_sel};
  endfunction

  task automatic model_clear();
    m_state = 0; m_x = 0; m_dir = 0; m_fc = 0; m_pal = 0; m_prev_mode = 0;
  endtask

  task automatic model_step();
    int s;
    bit en, pa, md;
    s  = int'(bus.speed);
    en = bus.enable;
    pa = bus.pause;
    md = bus.mode;
    if (m_state == 0) begin
      if (en) m_state = 1;
    end else if (!en) begin
      model_clear();
    end else if (m_state == 1 && pa) begin
      m_state = 2;
    end else if (m_state == 2) begin
      if (!pa) m_state = 1;
    end else begin
      if (md && !m_prev_mode && m_x > XMax) begin
        m_x = XMax; m_dir = 1;
      end else if (!md) begin
        m_x = (m_x + s) % 1024;
      end else if (m_dir == 0) begin
        if (m_x + s > XMax) begin m_x = XMax; m_dir = 1; end
        else m_x = m_x + s;
      end else if (m_x < s) begin
        m_x = 0; m_dir = 0;
      end else begin
        m_x = m_x - s;
      end
      m_prev_mode = md;
      m_fc = (m_fc + 1) % 256;
      if (m_fc % (1 << PalLog2) == 0) m_pal = (m_pal + 1) % 4;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.vsync = 1'b0; bus.enable = 1'b0; bus.pause = 1'b0; bus.mode = 1'b0; bus.speed = 4'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
  endtask

  // One frame boundary: low gap, rising edge, then sample the tick pulse and settled outputs.
  task automatic frame_edge();
    bus.vsync = 1'b0;
    repeat (3) @(negedge clk);
    bus.vsync = 1'b1;
    model_step();
    @(negedge clk);
    tick_hi = bus.frame_tick;
    @(negedge clk);
    tick_lo = bus.frame_tick;
    bus.vsync = 1'b0;
  endtask

  task automatic test_reset();
    int t0;
    rst_n = 1'b0;
    bus.vsync = 1'b1; bus.enable = 1'b1; bus.pause = 1'b0; bus.mode = 1'b0; bus.speed = 4'd5;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    t0 = tick_cnt;
    repeat (1000) @(negedge clk);
    tests_run++;
    if (tick_cnt - t0 !== 0) begin
      tests_failed++;
      $display("FAIL reset_no_tick: got %0d ticks want 0", tick_cnt - t0);
    end
    tests_run++;
    if (dut_vec() !== 23'd0 || bus.frame_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h want 0", dut_vec());
    end
  endtask

  task automatic test_wrap_run();
    apply_reset();
    bus.enable = 1'b1; bus.mode = 1'b0; bus.speed = 4'd10;
    for (int i = 1; i <= 110; i++) begin
      frame_edge();
      tests_run++;
      if (dut_vec() !== exp_vec() || tick_hi !== 1'b1 || tick_lo !== 1'b0) begin
        tests_failed++;
        $display("FAIL wrap_edge %0d: got %h tick %b%b want %h tick 10",
                 i, dut_vec(), tick_hi, tick_lo, exp_vec());
      end
    end
    tests_run++;
    if (bus.scroll_x !== 10'd66 || bus.frame_count !== 8'd109 || bus.palette_sel !== 2'd2 ||
        bus.state !== 2'd1) begin
      tests_failed++;
      $display("FAIL wrap_final: got x=%0d fc=%0d pal=%0d st=%0d want 66 109 2 1",
               bus.scroll_x, bus.frame_count, bus.palette_sel, bus.state);
    end
  endtask

  task automatic test_bounce();
    int ex, ed;
    apply_reset();
    bus.enable = 1'b1; bus.mode = 1'b0; bus.speed = 4'd10;
    repeat (51) frame_edge();
    tests_run++;
    if (bus.scroll_x !== 10'd500 || bus.dir !== 1'b0) begin
      tests_failed++;
      $display("FAIL bounce_setup: got x=%0d want 500", bus.scroll_x);
    end
    bus.mode = 1'b1; bus.speed = 4'd15;
    for (int i = 0; i <= 35; i++) begin
      frame_edge();
      if (i <= 34) begin ex = 511 - 15 * i; ed = 1; end
      else begin ex = 0; ed = 0; end
      tests_run++;
      if (bus.scroll_x !== 10'(ex) || bus.dir !== 1'(ed) || dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL bounce_step %0d: got x=%0d dir=%b want x=%0d dir=%0d",
                 i, bus.scroll_x, bus.dir, ex, ed);
      end
    end
  endtask

  task automatic test_pause();
    logic [9:0] held;
    frame_edge();
    held = bus.scroll_x;
    bus.pause = 1'b1;
    repeat (4) @(negedge clk);
    tests_run++;
    if (bus.scroll_x !== held || bus.state !== 2'd1) begin
      tests_failed++;
      $display("FAIL pause_midframe: got x=%0d st=%0d want x=%0d st=1", bus.scroll_x, bus.state, held);
    end
    for (int i = 0; i < 6; i++) begin
      frame_edge();
      tests_run++;
      if (bus.scroll_x !== held || bus.state !== 2'd2 || dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL pause_hold %0d: got x=%0d st=%0d want x=%0d st=2", i, bus.scroll_x, bus.state, held);
      end
    end
    bus.pause = 1'b0;
    frame_edge();
    tests_run++;
    if (bus.scroll_x !== held || bus.state !== 2'd1) begin
      tests_failed++;
      $display("FAIL pause_resume: got x=%0d st=%0d want x=%0d st=1", bus.scroll_x, bus.state, held);
    end
    frame_edge();
    tests_run++;
    if (bus.scroll_x !== held + 10'd15) begin
      tests_failed++;
      $display("FAIL pause_advance: got x=%0d want %0d", bus.scroll_x, held + 10'd15);
    end
  endtask

  task automatic test_idle_priority();
    bus.enable = 1'b0; bus.pause = 1'b1;
    frame_edge();
    tests_run++;
    if (dut_vec() !== 23'd0) begin
      tests_failed++;
      $display("FAIL idle_priority: got %h want 0", dut_vec());
    end
    bus.pause = 1'b0;
  endtask

  task automatic test_speed_midframe();
    apply_reset();
    bus.enable = 1'b1; bus.mode = 1'b0; bus.speed = 4'd3;
    frame_edge();
    frame_edge();
    bus.speed = 4'd7;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.scroll_x !== 10'd3) begin
      tests_failed++;
      $display("FAIL speed_midframe_hold: got x=%0d want 3", bus.scroll_x);
    end
    frame_edge();
    tests_run++;
    if (bus.scroll_x !== 10'd10) begin
      tests_failed++;
      $display("FAIL speed_midframe_tick: got x=%0d want 10", bus.scroll_x);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      bus.enable = ($urandom_range(0, 99) < 90);
      bus.pause  = ($urandom_range(0, 99) < 15);
      bus.mode   = ($urandom_range(0, 99) < 55);
      bus.speed  = 4'($urandom_range(0, 15));
      frame_edge();
      tests_run++;
      if (dut_vec() !== exp_vec() || tick_hi !== 1'b1 || tick_lo !== 1'b0) begin
        tests_failed++;
        $display("FAIL random_frame %0d: got %h tick %b%b want %h tick 10",
                 i, dut_vec(), tick_hi, tick_lo, exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    bus.enable = 1'b1; bus.pause = 1'b0; bus.mode = 1'b1; bus.speed = 4'd9;
    repeat (5) frame_edge();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.vsync = 1'b1;
    #1;
    tests_run++;
    if (dut_vec() !== 23'd0 || bus.frame_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got %h want 0", dut_vec());
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.state !== 2'd0 || bus.frame_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_release: got st=%0d tick=%b want 0 0", bus.state, bus.frame_tick);
    end
    frame_edge();
    tests_run++;
    if (dut_vec() !== exp_vec() || tick_hi !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_first_edge: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_wrap_run();
    test_bounce();
    test_pause();
    test_idle_priority();
    test_speed_midframe();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vga_anim_sequencer.md
VGA_ANIM_SEQUENCER -- requirements
Module: vga_anim_sequencer

Interface
REQ-001 Parameter X_MAX, default 511: upper bound of scroll_x in bounce mode (range 16..1023).
REQ-002 Parameter PAL_DIV_LOG2, default 4: palette_sel advances every 2^PAL_DIV_LOG2 RUN frames.
REQ-003 clk  in  1  pixel clock; single clock domain.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 vsync  in  1  vertical sync from the timing generator, synchronous to clk; a frame boundary is its rising edge.
REQ-006 enable  in  1  run request; sampled only at frame_tick.
REQ-007 pause  in  1  hold animation; sampled only at frame_tick.
REQ-008 mode  in  1  0 = wrap scroll, 1 = bounce scroll; sampled only at frame_tick.
REQ-009 speed  in  4  pixels per frame added to or subtracted from scroll_x; sampled only at frame_tick.
REQ-010 scroll_x  out  10  horizontal offset for the pixel datapath.
REQ-011 palette_sel  out  2  colour-scheme index for the pixel datapath.
REQ-012 frame_count  out  8  count of frames spent in RUN, modulo 256.
REQ-013 frame_tick  out  1  one-cycle pulse marking each frame boundary.
REQ-014 state  out  2  FSM state: 0 IDLE, 1 RUN, 2 HOLD.
REQ-015 dir  out  1  bounce direction: 0 increasing, 1 decreasing.

Function
REQ-016 vsync is registered once (vsync_q); frame_tick = vsync & ~vsync_q, registered so it asserts the cycle after the rising edge, for exactly one cycle.
REQ-017 All config inputs are acted on only in the cycle frame_tick is high; mid-frame changes have no effect until the next tick.
REQ-018 Every output register update occurs in the frame_tick cycle; outputs are stable for the rest of the frame.
REQ-019 IDLE: on tick with enable=1 go to RUN (no motion that tick); otherwise stay.
REQ-020 RUN: on tick, enable=0 -> IDLE; else pause=1 -> HOLD (no motion that tick); else advance per REQ-023..026.
REQ-021 HOLD: on tick, enable=0 -> IDLE; else pause=0 -> RUN (no motion that tick); outputs frozen while in HOLD.
REQ-022 enable=0 has priority over pause; entry to IDLE clears scroll_x, frame_count, palette_sel and dir to 0.
REQ-023 Wrap mode: scroll_x <= (scroll_x + speed) mod 1024; dir unchanged.
REQ-024 Bounce, dir=0: if scroll_x + speed > X_MAX then scroll_x <= X_MAX and dir <= 1, else scroll_x += speed.
REQ-025 Bounce, dir=1: if scroll_x < speed then scroll_x <= 0 and dir <= 0, else scroll_x -= speed.
REQ-026 speed=0 leaves scroll_x and dir unchanged in both modes; a mode switch 0->1 with scroll_x > X_MAX clamps scroll_x to X_MAX on that tick and sets dir=1.
REQ-027 Each advancing RUN tick increments frame_count (wrapping 255->0); palette_sel increments (mod 4) when the new frame_count low PAL_DIV_LOG2 bits are all zero.
REQ-028 All sums computed 11 bits wide before compare; no silent truncation in bounce mode.

Reset
REQ-029 On rst_n low: state=IDLE, scroll_x=0, palette_sel=0, frame_count=0, frame_tick=0, dir=0, vsync_q=1 (no spurious tick if vsync is high at reset release).
REQ-030 Reset mid-frame or mid-bounce takes effect immediately, asynchronously; release is followed by normal tick detection.

Structure
REQ-031 Shared package vga_pkg holds the state enumeration (IDLE/RUN/HOLD), the 10-bit coordinate width constant and the mode encodings.
REQ-032 One sub-module, vga_frame_edge, implements REQ-016 (vsync register + tick pulse); all else stays in a single FSM + datapath block.

Verification
REQ-033 Reset release with vsync held 1, no vsync edges for 1000 cycles -> frame_tick never asserts, all outputs 0.
REQ-034 enable=1, mode=0, speed=10, 110 vsync rising edges -> IDLE->RUN on edge 1, then scroll_x = 10*109 mod 1024 = 66, frame_count=109, palette_sel=2 (109>>4 = 6, mod 4).
REQ-035 mode=1, speed=15, X_MAX=511, scroll_x at 500 dir=0 -> next tick scroll_x=511 dir=1, next 496, ... down to 1, then 0 with dir=0.
REQ-036 pause=1 asserted mid-frame in RUN -> scroll_x unchanged until tick, state=HOLD after tick, frozen for 5 frames; pause=0 -> RUN with one non-advancing tick.
REQ-037 enable=0 and pause=1 together at a RUN tick -> state=IDLE, scroll_x, frame_count, palette_sel, dir all 0.
REQ-038 speed changed 3->7 at mid-frame -> that frame's tick uses 7; no output change before the tick.
